// File: rtl/tx_queue_pkg.sv
// Shared definitions for the UART transmit byte queue.
// Holds the default queue depth and the launch-sequencer state encoding.
// Imported by byte_fifo and tx_byte_queue.
package tx_queue_pkg;

    localparam int TXQ_DEPTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_ACT  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_WAIT_CLR  = 3'd4
    } txq_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer: DEPTH entries, head visible on dout_o with no read latency.
// Ports: clk_i/rst_ni, push_i/din_i (write), pop_i (drop head), dout_o (head),
//        full_o/empty_o/count_o (occupancy). A push while full only lands if a pop
//        happens in the same cycle; otherwise it is silently dropped.
module byte_fifo
    import tx_queue_pkg::*;
#(
    parameter int DEPTH = TXQ_DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [7:0]               din_i,
    input  logic                     pop_i,
    output logic [7:0]               dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A same-cycle pop frees the head slot, so a push is still taken when full.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // DEPTH is a power of two, so the natural AW-bit rollover is the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/tx_byte_queue.sv
// Byte queue feeding a UART transmitter: buffers producer bytes and launches one
// byte per Tx_DV pulse, waiting for the transmitter's Active/Done handshake to
// complete (Done risen and fallen) before the next launch.
// Ports: Clk/Rst_n; In_Valid/In_Byte/In_Ready producer side; Tx_DV/Tx_Byte out,
//        Tx_Active/Tx_Done in (transmitter side); Count/Empty occupancy.
// Build option: define TX_QUEUE_OVF_EN to add the sticky Overflow output.
module tx_byte_queue
    import tx_queue_pkg::*;
#(
    parameter int DEPTH = TXQ_DEPTH_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     In_Valid,
    input  logic [7:0]               In_Byte,
    output logic                     In_Ready,
    output logic                     Tx_DV,
    output logic [7:0]               Tx_Byte,
    input  logic                     Tx_Active,
    input  logic                     Tx_Done,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty
`ifdef TX_QUEUE_OVF_EN
    ,
    output logic                     Overflow
`endif
);

    txq_state_e state_q, state_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .push_i  (In_Valid),
        .din_i   (In_Byte),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (Count)
    );

    assign Empty    = fifo_empty;
    assign In_Ready = !fifo_full;
    assign Tx_DV    = (state_q == ST_LAUNCH);
    assign Tx_Byte  = tx_byte_q;

    // The byte register is loaded on the IDLE->LAUNCH edge so that Tx_Byte
    // already shows the head entry during the Tx_DV cycle; the pop in LAUNCH
    // then retires that same entry.
    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Also guards a transmitter that kept running through our reset.
                if (!fifo_empty && !Tx_Active && !Tx_Done) begin
                    state_d   = ST_LAUNCH;
                    tx_byte_d = fifo_head;
                end
            end
            ST_LAUNCH: begin
                fifo_pop = 1'b1;
                state_d  = ST_WAIT_ACT;
            end
            ST_WAIT_ACT: begin
                if (Tx_Active) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (Tx_Done) state_d = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                // Done may be held for several cycles; wait for it to drop.
                if (!Tx_Done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            tx_byte_q <= tx_byte_d;
        end
    end

`ifdef TX_QUEUE_OVF_EN
    logic ovf_q;

    // A write is lost only when full and the launcher is not popping this cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ovf_q <= 1'b0;
        end else if (In_Valid && fifo_full && !fifo_pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_tx_byte_queue.sv
module tb_tx_byte_queue;

    localparam int DEPTH = 16;
    localparam int CPB   = 4;
    localparam int U_IDLE = 0, U_START = 1, U_DATA = 2, U_STOP = 3, U_DONE = 4;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       In_Valid = 1'b0;
    logic [7:0] In_Byte = 8'h00;
    logic       In_Ready;
    logic       Tx_DV;
    logic [7:0] Tx_Byte;
    logic [4:0] Count;
    logic       Empty;
    logic       busy_force = 1'b0;
    logic       tx_act_dut;
`ifdef TX_QUEUE_OVF_EN
    logic       Overflow;
`endif

    always #5 Clk = ~Clk;

    // ---------------- UART transmitter model (no reset, CLKS_PER_BIT=4) ----
    int         us = U_IDLE;
    int         ccnt = 0;
    int         bidx = 0;
    int         dcnt = 0;
    int         done_hold = 1;
    logic [7:0] sh = 8'h00;
    logic       u_act = 1'b0;
    logic       u_done = 1'b0;
    logic       uart_ser;

    assign uart_ser   = (us == U_START) ? 1'b0 : (us == U_DATA) ? sh[bidx] : 1'b1;
    assign tx_act_dut = u_act | busy_force;

    always @(posedge Clk) begin
        case (us)
            U_IDLE: if (Tx_DV) begin
                sh <= Tx_Byte; u_act <= 1'b1; ccnt <= 0; us <= U_START;
            end
            U_START: if (ccnt == CPB-1) begin ccnt <= 0; bidx <= 0; us <= U_DATA; end
                     else ccnt <= ccnt + 1;
            U_DATA: if (ccnt == CPB-1) begin
                ccnt <= 0;
                if (bidx == 7) us <= U_STOP; else bidx <= bidx + 1;
            end else ccnt <= ccnt + 1;
            U_STOP: if (ccnt == CPB-1) begin
                ccnt <= 0; u_act <= 1'b0; u_done <= 1'b1; dcnt <= done_hold - 1; us <= U_DONE;
            end else ccnt <= ccnt + 1;
            default: if (dcnt == 0) begin u_done <= 1'b0; us <= U_IDLE; end
                     else dcnt <= dcnt - 1;
        endcase
    end

    tx_byte_queue #(.DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In_Valid  (In_Valid),
        .In_Byte   (In_Byte),
        .In_Ready  (In_Ready),
        .Tx_DV     (Tx_DV),
        .Tx_Byte   (Tx_Byte),
        .Tx_Active (tx_act_dut),
        .Tx_Done   (u_done),
        .Count     (Count),
        .Empty     (Empty)
`ifdef TX_QUEUE_OVF_EN
        ,
        .Overflow  (Overflow)
`endif
    );

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    logic [7:0] line_q[$];
    int         mcount = 0;
    int         n_dv = 0;
    int         n_rx = 0;
    logic       ovf_exp = 1'b0;
    logic       pending_done = 1'b0;
    logic       done_rose = 1'b0;
    logic [7:0] last_byte = 8'h00;
    logic [7:0] last_rx = 8'h00;
    logic       rx_busy = 1'b0;

    always @(negedge Clk) begin
        if (Rst_n) begin
            int  c0;
            logic [7:0] e;
            if (pending_done) begin
                if (u_done) done_rose = 1'b1;
                else if (done_rose) pending_done = 1'b0;
            end
            c0 = mcount;
            if (Tx_DV) begin
                n_dv++;
                check("dv_xmit_idle", {30'd0, tx_act_dut, u_done}, 32'd0);
                check("dv_done_cycle", {31'd0, pending_done}, 32'd0);
                pending_done = 1'b1;
                done_rose    = 1'b0;
                if (exp_q.size() == 0) begin
                    check("dv_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {24'd0, Tx_Byte}, {24'd0, e});
                    line_q.push_back(e);
                    mcount--;
                end
                last_byte = Tx_Byte;
            end else if (Tx_Byte !== last_byte) begin
                check("tx_byte_stable", {24'd0, Tx_Byte}, {24'd0, last_byte});
            end
            if (In_Valid) begin
                if (c0 < DEPTH || Tx_DV) begin
                    exp_q.push_back(In_Byte);
                    mcount++;
                end else begin
                    ovf_exp = 1'b1;
                end
            end
        end else begin
            last_byte = 8'h00;
        end
    end

    // ---------------- serial line decoder ----------------
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge Clk);
            if (uart_ser === 1'b0) begin
                rx_busy = 1'b1;
                repeat (2) @(negedge Clk);
                check("line_start", {31'd0, uart_ser}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge Clk);
                    b[i] = uart_ser;
                end
                repeat (CPB) @(negedge Clk);
                check("line_stop", {31'd0, uart_ser}, 32'd1);
                if (line_q.size() == 0) begin
                    check("line_unexpected", 32'd1, 32'd0);
                end else begin
                    e = line_q.pop_front();
                    check("line_byte", {24'd0, b}, {24'd0, e});
                end
                last_rx = b;
                n_rx++;
                rx_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [7:0] b);
        In_Valid = 1'b1;
        In_Byte  = b;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
    endtask

    task automatic wait_dv(input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge Clk); #1;
            if (Tx_DV) begin ok = 1'b1; break; end
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clk);
            if (mcount == 0 && Empty && us == U_IDLE && !u_done && !rx_busy
                && line_q.size() == 0 && !Tx_DV) begin
                ok = 1'b1; break;
            end
        end
        check(tag, {31'd0, ok}, 32'd1);
        @(posedge Clk); #1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        exp_q.delete();
        mcount  = 0;
        ovf_exp = 1'b0;
        #1;
    endtask

    // ---------------- main sequence ----------------
    int dv0, rx0;
    logic ok_w;

    initial begin
        // reset state
        #1;
        check("rst_count",  {27'd0, Count}, 32'd0);
        check("rst_empty",  {31'd0, Empty}, 32'd1);
        check("rst_ready",  {31'd0, In_Ready}, 32'd1);
        check("rst_dv",     {31'd0, Tx_DV}, 32'd0);
        check("rst_byte",   {24'd0, Tx_Byte}, 32'd0);
`ifdef TX_QUEUE_OVF_EN
        check("rst_ovf",    {31'd0, Overflow}, 32'd0);
`endif
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (2) @(posedge Clk); #1;

        // single byte, latency 2
        wr(8'hA5);
        check("lat_early_dv", {31'd0, Tx_DV}, 32'd0);
        @(posedge Clk); #1;
        check("lat_dv", {31'd0, Tx_DV}, 32'd1);
        check("lat_byte", {24'd0, Tx_Byte}, 32'hA5);
        @(posedge Clk); #1;
        check("dv_one_cycle", {31'd0, Tx_DV}, 32'd0);
        wait_drain("drain_a5");
        check("a5_line", {24'd0, last_rx}, 32'hA5);

        // burst fill with transmitter busy, overflow, push+pop at full
        dv0 = n_dv;
        busy_force = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            wr(8'(i));
            if (i == DEPTH-1) check("ready_15", {31'd0, In_Ready}, 32'd1);
        end
        check("full_ready", {31'd0, In_Ready}, 32'd0);
        check("full_count", {27'd0, Count}, 32'd16);
        check("full_empty", {31'd0, Empty}, 32'd0);
        wr(8'hEE);
        check("drop_count", {27'd0, Count}, 32'd16);
        check("drop_model", mcount, 32'd16);
`ifdef TX_QUEUE_OVF_EN
        check("drop_ovf", {31'd0, Overflow}, {31'd0, ovf_exp});
        check("drop_ovf_set", {31'd0, Overflow}, 32'd1);
`endif
        busy_force = 1'b0;
        wait_dv("pp_wait_dv");
        check("pp_count_pre", {27'd0, Count}, 32'd16);
        wr(8'h11);
        check("pp_count", {27'd0, Count}, 32'd16);
        check("pp_ready", {31'd0, In_Ready}, 32'd0);
        wait_drain("drain_burst");
        check("burst_dv", n_dv - dv0, 32'd17);
`ifdef TX_QUEUE_OVF_EN
        check("ovf_sticky", {31'd0, Overflow}, 32'd1);
`endif

        // transmitter holds Done for two cycles
        dv0 = n_dv; rx0 = n_rx;
        done_hold = 2;
        for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i));
        wait_drain("drain_hold");
        check("hold_dv", n_dv - dv0, 32'd4);
        check("hold_rx", n_rx - rx0, 32'd4);
        done_hold = 1;

        // reset mid-transmission with 5 queued
        dv0 = n_dv;
        for (int i = 0; i < 6; i++) wr(8'h50 + 8'(i));
        ok_w = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (u_act) begin ok_w = 1'b1; break; end
            @(posedge Clk); #1;
        end
        check("mid_active", {31'd0, ok_w}, 32'd1);
        repeat (5) @(posedge Clk); #1;
        check("pre_rst_count", {27'd0, Count}, 32'd5);
        do_reset();
        check("mid_rst_count", {27'd0, Count}, 32'd0);
        check("mid_rst_dv", {31'd0, Tx_DV}, 32'd0);
        check("mid_rst_empty", {31'd0, Empty}, 32'd1);
        check("mid_rst_ready", {31'd0, In_Ready}, 32'd1);
        check("mid_rst_byte", {24'd0, Tx_Byte}, 32'd0);
`ifdef TX_QUEUE_OVF_EN
        check("mid_rst_ovf", {31'd0, Overflow}, 32'd0);
`endif
        @(posedge Clk); #1 Rst_n = 1'b1;
        check("mid_still_busy", {31'd0, u_act}, 32'd1);
        wr(8'h3C);
        ok_w = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (u_done) begin ok_w = 1'b1; break; end
            @(posedge Clk); #1;
        end
        check("mid_done_seen", {31'd0, ok_w}, 32'd1);
        check("mid_no_launch", {31'd0, Tx_DV}, 32'd0);
        check("mid_held_count", {27'd0, Count}, 32'd1);
        wait_drain("drain_mid");
        check("mid_dv", n_dv - dv0, 32'd2);
        check("mid_last_line", {24'd0, last_rx}, 32'h3C);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
